// File: rtl/adder_lab_pkg.sv
// Shared types and constants for the 4-bit adder lab front end.
// The ADD_SEQ_DEBOUNCE_EN build option only affects button_conditioner; nothing here depends on it.
package adder_lab_pkg;

  localparam int ADDER_WIDTH = 4;

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    SETTLE = 2'd2,
    SHOW   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/button_conditioner.sv
// Button front end: 2-FF synchronizer, optional debounce (ADD_SEQ_DEBOUNCE_EN), rising-edge pulse.
// The pulse is combinational from registered state, so it lands 2 cycles after the raw level change.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;
  logic stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef ADD_SEQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             stable_reg;

  // Count consecutive cycles that disagree with the accepted level; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else if (sync2_reg == stable_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg    <= '0;
      stable_reg <= sync2_reg;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign stable = stable_reg;
`else
  assign stable = sync2_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= stable;
    end
  end

  assign pulse = stable & ~prev_reg;

endmodule

// File: rtl/adder_operand_sequencer.sv
// Captures A, then B/carry-in from switches on button presses and latches the adder's {cout, sum}.
// Debounce inside the button conditioners is enabled by defining ADD_SEQ_DEBOUNCE_EN.
module adder_operand_sequencer
  import adder_lab_pkg::*;
#(
  parameter int WIDTH           = ADDER_WIDTH,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             cin_sw,
  input  logic             btn_next,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic [1:0]       phase
);

  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;
  logic       next_p;
  logic       clear_p;

  assign btn_raw = {btn_clear, btn_next};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cond (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_raw[gi]),
        .pulse(btn_pulse[gi])
      );
    end
  endgenerate

  assign next_p  = btn_pulse[0];
  assign clear_p = btn_pulse[1];

  seq_state_t       state_reg,  state_next;
  logic [WIDTH-1:0] op_a_reg,   op_a_next;
  logic [WIDTH-1:0] op_b_reg,   op_b_next;
  logic             op_cin_reg, op_cin_next;
  logic [WIDTH:0]   result_reg, result_next;
  logic             valid_reg,  valid_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= WAIT_A;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      op_cin_reg <= 1'b0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_a_reg   <= op_a_next;
      op_b_reg   <= op_b_next;
      op_cin_reg <= op_cin_next;
      result_reg <= result_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_a_next   = op_a_reg;
    op_b_next   = op_b_reg;
    op_cin_next = op_cin_reg;
    result_next = result_reg;
    valid_next  = valid_reg;
    if (clear_p) begin
      // Clear overrides any simultaneous next press, in every state.
      state_next  = WAIT_A;
      op_a_next   = '0;
      op_b_next   = '0;
      op_cin_next = 1'b0;
      result_next = '0;
      valid_next  = 1'b0;
    end else begin
      case (state_reg)
        WAIT_A: begin
          if (next_p) begin
            op_a_next  = sw;
            state_next = WAIT_B;
          end
        end
        WAIT_B: begin
          if (next_p) begin
            op_b_next   = sw;
            op_cin_next = cin_sw;
            state_next  = SETTLE;
          end
        end
        SETTLE: begin
          // Operands have been stable through the combinational adder for a full cycle.
          result_next = {cout, sum};
          valid_next  = 1'b1;
          state_next  = SHOW;
        end
        SHOW: begin
          if (next_p) begin
            valid_next = 1'b0;
            state_next = WAIT_A;
          end
        end
        default: state_next = WAIT_A;
      endcase
    end
  end

  assign op_a         = op_a_reg;
  assign op_b         = op_b_reg;
  assign op_cin       = op_cin_reg;
  assign result       = result_reg;
  assign result_valid = valid_reg;
  assign phase        = state_reg;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed bench for adder_operand_sequencer with DEBOUNCE_CYCLES=4 and a behavioural adder alongside.
// Debounce-specific vectors run only when ADD_SEQ_DEBOUNCE_EN is defined; exact latency only without it.
module tb_adder_operand_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw = '0;
  logic         cin_sw = 1'b0;
  logic         btn_next = 1'b0;
  logic         btn_clear = 1'b0;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic [W-1:0] sum;
  logic         cout;
  logic [W:0]   result;
  logic         result_valid;
  logic [1:0]   phase;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {cout, sum} = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin};

  adder_operand_sequencer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .cin_sw      (cin_sw),
    .btn_next    (btn_next),
    .btn_clear   (btn_clear),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .sum         (sum),
    .cout        (cout),
    .result      (result),
    .result_valid(result_valid),
    .phase       (phase)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Hold next until the phase moves (bounded), record the next phase too, then release cleanly.
  task automatic press_next(input logic [W-1:0] s, input logic c, output int lat,
                            output logic [1:0] first_ph, output logic [1:0] later_ph);
    logic [1:0] start;
    start    = phase;
    sw       = s;
    cin_sw   = c;
    btn_next = 1'b1;
    lat      = 0;
    while (phase == start && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    first_ph = phase;
    @(negedge clk);
    later_ph = phase;
    repeat (12) @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic count_changes(input int cycles, output int changes);
    logic [1:0] last;
    last    = phase;
    changes = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (phase != last) changes++;
      last = phase;
    end
  endtask

  initial begin
    int         lat;
    int         chg;
    logic [1:0] p1;
    logic [1:0] p2;

    @(negedge clk);
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_op_cin", op_cin, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_phase", phase, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 5 + 3 + 0 = 8
    press_next(4'b0101, 1'b0, lat, p1, p2);
    check("a_phase", p1, 1);
    check("a_op_a", op_a, 4'b0101);
`ifndef ADD_SEQ_DEBOUNCE_EN
    check("a_latency", lat, 3);
`endif
    press_next(4'b0011, 1'b0, lat, p1, p2);
    check("b_settle", p1, 2);
    check("b_show", p2, 3);
    check("b_result", result, 5'b01000);
    check("b_valid", result_valid, 1);

    // Leaving SHOW keeps the result and operands
    press_next(4'b1111, 1'b0, lat, p1, p2);
    check("show_exit_phase", p1, 0);
    check("show_exit_valid", result_valid, 0);
    check("show_exit_result", result, 5'b01000);
    check("show_exit_op_a", op_a, 4'b0101);

    // 15 + 1 + 1 = 17
    press_next(4'b1111, 1'b0, lat, p1, p2);
    press_next(4'b0001, 1'b1, lat, p1, p2);
    check("c_op_cin", op_cin, 1);
    check("c_result", result, 5'b10001);
    check("c_valid", result_valid, 1);
    press_next(4'b0000, 1'b0, lat, p1, p2);
    check("c_exit_phase", phase, 0);
    check("c_exit_valid", result_valid, 0);
    check("c_exit_result", result, 5'b10001);

`ifdef ADD_SEQ_DEBOUNCE_EN
    // A 3-cycle glitch is shorter than the debounce window
    btn_next = 1'b1;
    count_changes(3, chg);
    btn_next = 1'b0;
    count_changes(15, lat);
    check("glitch_changes", chg + lat, 0);
    check("glitch_phase", phase, 0);
`endif

    // A 10-cycle hold gives exactly one transition, none on release
    sw       = 4'b1010;
    btn_next = 1'b1;
    count_changes(10, chg);
    btn_next = 1'b0;
    count_changes(15, lat);
    check("hold_changes", chg + lat, 1);
    check("hold_phase", phase, 1);
    check("hold_op_a", op_a, 4'b1010);

    // Simultaneous clear and next in WAIT_B: clear wins
    btn_next  = 1'b1;
    btn_clear = 1'b1;
    repeat (15) @(negedge clk);
    btn_next  = 1'b0;
    btn_clear = 1'b0;
    repeat (15) @(negedge clk);
    check("clr_phase", phase, 0);
    check("clr_op_a", op_a, 0);
    check("clr_result", result, 0);
    check("clr_valid", result_valid, 0);

    // Asynchronous reset from SHOW
    press_next(4'b0101, 1'b0, lat, p1, p2);
    press_next(4'b0011, 1'b0, lat, p1, p2);
    check("pre_rst_result", result, 5'b01000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_op_a", op_a, 0);
    check("arst_op_b", op_b, 0);
    check("arst_result", result, 0);
    check("arst_valid", result_valid, 0);
    check("arst_phase", phase, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
